// File: rtl/iq_dispatch.sv
// Issue-queue write side: steers up to 4 renamed uops/cycle into two lane FIFOs and presents
// up to 2 uops per lane to the issue queue. Define IQ_DISPATCH_STATS_EN for stall/kill counters.
module iq_dispatch #(
    parameter int DEPTH     = 8,
    parameter int WIDTH_REG = 5,
    parameter int WIDTH_TAG = 5,
    parameter int WIDTH_BRM = 3,
    parameter int WIDTH     = 7 + WIDTH_BRM + WIDTH_TAG + 3*WIDTH_REG + 3
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [WIDTH-1:0]     i_uop1,
    input  logic [WIDTH-1:0]     i_uop2,
    input  logic [WIDTH-1:0]     i_uop3,
    input  logic [WIDTH-1:0]     i_uop4,
    input  logic [3:0]           i_valid,
    input  logic [3:0]           i_lane,
    output logic                 o_ready,
    output logic [WIDTH-1:0]     o_inst0a,
    output logic [WIDTH-1:0]     o_inst0b,
    output logic [WIDTH-1:0]     o_inst1a,
    output logic [WIDTH-1:0]     o_inst1b,
    output logic [3:0]           o_ivalid,
    input  logic [1:0]           i_iq_ready,
    input  logic [WIDTH_BRM-1:0] i_BrKill
`ifdef IQ_DISPATCH_STATS_EN
    ,
    output logic [31:0]          o_stall_cnt,
    output logic [31:0]          o_kill_cnt
`endif
);
    localparam int PW     = $clog2(DEPTH);
    localparam int CW     = PW + 1;
    localparam int BRM_HI = WIDTH - 8;
    localparam logic [CW-1:0] READY_MAX = CW'(DEPTH - 4);

    function automatic logic f_hit(input logic [WIDTH_BRM-1:0] brm, input logic [WIDTH_BRM-1:0] kill);
        return |(brm & kill);
    endfunction

    logic [WIDTH-1:0]      w_uop [4];
    logic [3:0]            w_push_en;
    logic [3:0]            w_uop_hit;
    logic [1:0]            w_push_ofs [4];
    logic [2:0]            w_push_cnt [2];
    logic [1:0][CW-1:0]    w_count;
    logic [1:0][WIDTH-1:0] w_inst_a;
    logic [1:0][WIDTH-1:0] w_inst_b;
    logic [1:0]            w_val_a;
    logic [1:0]            w_val_b;
    logic [1:0][DEPTH-1:0] w_kill_hit;

    assign w_uop[0] = i_uop1;
    assign w_uop[1] = i_uop2;
    assign w_uop[2] = i_uop3;
    assign w_uop[3] = i_uop4;

    // Only registered counts gate rename; same-cycle pops are deliberately not credited.
    assign o_ready = !i_rst && (w_count[0] <= READY_MAX) && (w_count[1] <= READY_MAX);

    // NOTE: w_push_cnt is a running tally inside one combinational pass, so blocking '=' is intended here.
    always_comb begin
        w_push_cnt[0] = '0;
        w_push_cnt[1] = '0;
        for (int k = 0; k < 4; k++) begin
            w_push_en[k]  = o_ready && i_valid[k];
            w_uop_hit[k]  = f_hit(w_uop[k][BRM_HI -: WIDTH_BRM], i_BrKill);
            w_push_ofs[k] = w_push_cnt[i_lane[k]][1:0];
            if (w_push_en[k]) begin
                w_push_cnt[i_lane[k]] = w_push_cnt[i_lane[k]] + 3'd1;
            end
        end
    end

    for (genvar l = 0; l < 2; l++) begin : g_lane
        logic [WIDTH-1:0] r_mem [DEPTH];
        logic [DEPTH-1:0] r_live;
        logic [PW-1:0]    r_wr_ptr;
        logic [PW-1:0]    r_rd_ptr;
        logic [CW-1:0]    r_count;
        logic [PW-1:0]    w_rd_ptr_b;
        logic             w_pres_a;
        logic             w_pres_b;
        logic [1:0]       w_pops;
        logic [DEPTH-1:0] w_kill_hit_l;

        assign w_rd_ptr_b = r_rd_ptr + PW'(1);
        assign w_pres_a   = (r_count != '0);
        assign w_pres_b   = (r_count > CW'(1));
        assign w_pops     = i_iq_ready[l] ? (2'(w_pres_a) + 2'(w_pres_b)) : 2'd0;

        // An entry is occupied when its distance from the read pointer is below count.
        always_comb begin
            logic [PW-1:0] v_ofs;
            for (int i = 0; i < DEPTH; i++) begin
                v_ofs           = PW'(i) - r_rd_ptr;
                w_kill_hit_l[i] = ({1'b0, v_ofs} < r_count) && r_live[i]
                                  && f_hit(r_mem[i][BRM_HI -: WIDTH_BRM], i_BrKill);
            end
        end

        assign w_kill_hit[l] = w_kill_hit_l;
        assign w_count[l]    = r_count;
        assign w_val_a[l]    = w_pres_a && r_live[r_rd_ptr]
                               && !f_hit(r_mem[r_rd_ptr][BRM_HI -: WIDTH_BRM], i_BrKill);
        assign w_val_b[l]    = w_pres_b && r_live[w_rd_ptr_b]
                               && !f_hit(r_mem[w_rd_ptr_b][BRM_HI -: WIDTH_BRM], i_BrKill);
        assign w_inst_a[l]   = w_val_a[l] ? r_mem[r_rd_ptr]   : '0;
        assign w_inst_b[l]   = w_val_b[l] ? r_mem[w_rd_ptr_b] : '0;

        // NOTE: payload storage is not reset; count and live bits decide what is ever presented.
        always_ff @(posedge i_clk) begin
            for (int k = 0; k < 4; k++) begin
                if (w_push_en[k] && (i_lane[k] == 1'(l))) begin
                    r_mem[r_wr_ptr + PW'(w_push_ofs[k])] <= w_uop[k];
                end
            end
        end

        always_ff @(posedge i_clk) begin
            if (i_rst) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
                r_live   <= '0;
            end else begin
                r_wr_ptr <= r_wr_ptr + PW'(w_push_cnt[l]);
                r_rd_ptr <= r_rd_ptr + PW'(w_pops);
                r_count  <= r_count + CW'(w_push_cnt[l]) - CW'(w_pops);
                r_live   <= r_live & ~w_kill_hit_l;
                for (int k = 0; k < 4; k++) begin
                    if (w_push_en[k] && (i_lane[k] == 1'(l))) begin
                        r_live[r_wr_ptr + PW'(w_push_ofs[k])] <= !w_uop_hit[k];
                    end
                end
            end
        end
    end

    assign o_inst0a = w_inst_a[0];
    assign o_inst0b = w_inst_b[0];
    assign o_inst1a = w_inst_a[1];
    assign o_inst1b = w_inst_b[1];
    assign o_ivalid = {w_val_b[1], w_val_a[1], w_val_b[0], w_val_a[0]};

`ifdef IQ_DISPATCH_STATS_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_kill_cnt;
    logic [31:0] w_kill_inc;

    // Kills of buffered entries plus uops that arrive already killed.
    assign w_kill_inc = 32'($countones(w_kill_hit)) + 32'($countones(w_push_en & w_uop_hit));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_stall_cnt <= '0;
            r_kill_cnt  <= '0;
        end else begin
            if (!o_ready && (i_valid != 4'd0)) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
            r_kill_cnt <= r_kill_cnt + w_kill_inc;
        end
    end

    assign o_stall_cnt = r_stall_cnt;
    assign o_kill_cnt  = r_kill_cnt;
`endif
endmodule

// File: tb/tb_iq_dispatch.sv
// Scoreboard bench for iq_dispatch: directed vectors push expected insert pairs, a negedge
// monitor compares them whenever the issue queue accepts a presented pair.
`timescale 1ns/1ps
module tb_iq_dispatch;
    localparam int W      = 33;
    localparam int BRM_HI = W - 8;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] u1, u2, u3, u4;
    logic [3:0]   valid, lane;
    logic         ready;
    logic [W-1:0] inst0a, inst0b, inst1a, inst1b;
    logic [3:0]   ivalid;
    logic [1:0]   iq_ready;
    logic [2:0]   kill;
`ifdef IQ_DISPATCH_STATS_EN
    logic [31:0]  stall_cnt, kill_cnt;
`endif

    iq_dispatch dut (
        .i_clk(clk), .i_rst(rst),
        .i_uop1(u1), .i_uop2(u2), .i_uop3(u3), .i_uop4(u4),
        .i_valid(valid), .i_lane(lane), .o_ready(ready),
        .o_inst0a(inst0a), .o_inst0b(inst0b), .o_inst1a(inst1a), .o_inst1b(inst1b),
        .o_ivalid(ivalid), .i_iq_ready(iq_ready), .i_BrKill(kill)
`ifdef IQ_DISPATCH_STATS_EN
        , .o_stall_cnt(stall_cnt), .o_kill_cnt(kill_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a0, b0, a1, b1;
        logic [3:0]   iv;
    } exp_t;

    exp_t sb[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] mk(input logic [7:0] id, input logic [2:0] brm);
        logic [W-1:0] u;
        u             = '0;
        u[7:0]        = id;
        u[W-1 -: 7]   = id[6:0] ^ 7'h2a;
        u[BRM_HI -: 3] = brm;
        return u;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [3:0] v, input logic [3:0] ln,
                        input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] c, input logic [W-1:0] d);
        valid = v; lane = ln; u1 = a; u2 = b; u3 = c; u4 = d;
    endtask

    task automatic idle();
        valid = 4'd0; lane = 4'd0; u1 = '0; u2 = '0; u3 = '0; u4 = '0;
    endtask

    task automatic expect_tx(input logic [W-1:0] a0, input logic [W-1:0] b0,
                             input logic [W-1:0] a1, input logic [W-1:0] b1, input logic [3:0] iv);
        exp_t e;
        e.a0 = a0; e.b0 = b0; e.a1 = a1; e.b1 = b1; e.iv = iv;
        sb.push_back(e);
    endtask

    // Monitor: one expected transaction per cycle in which the issue queue accepts valid inserts.
    always @(negedge clk) begin
        if (!rst && (((|ivalid[1:0]) && iq_ready[0]) || ((|ivalid[3:2]) && iq_ready[1]))) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_miss++;
                $display("FAIL unexpected_insert: got ivalid=%b expected no insert", ivalid);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("mon_ivalid", 64'(ivalid), 64'(e.iv));
                check("mon_inst0a", 64'(inst0a), 64'(e.a0));
                check("mon_inst0b", 64'(inst0b), 64'(e.b0));
                check("mon_inst1a", 64'(inst1a), 64'(e.a1));
                check("mon_inst1b", 64'(inst1b), 64'(e.b1));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [W-1:0] g [8];
        rst = 1'b1; iq_ready = 2'b00; kill = 3'b000;
        idle();

        // Reset held for 3 cycles
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("rst_ready", 64'(ready), 64'd0);
            check("rst_ivalid", 64'(ivalid), 64'd0);
            check("rst_inst0a", 64'(inst0a), 64'd0);
            check("rst_inst1b", 64'(inst1b), 64'd0);
        end
        tick();
        rst = 1'b0;
        #1;
        check("post_rst_ready", 64'(ready), 64'd1);
        check("post_rst_ivalid", 64'(ivalid), 64'd0);

        // Four-wide steer: uop1,3 -> lane 0, uop2,4 -> lane 1
        push(4'b1111, 4'b1010, mk(8'h11, 3'b0), mk(8'h12, 3'b0), mk(8'h13, 3'b0), mk(8'h14, 3'b0));
        iq_ready = 2'b11;
        expect_tx(mk(8'h11, 3'b0), mk(8'h13, 3'b0), mk(8'h12, 3'b0), mk(8'h14, 3'b0), 4'b1111);
        tick();
        idle();
        tick();
        check("t2_drained", 64'(ivalid), 64'd0);

        // Back-pressure threshold at DEPTH-4
        iq_ready = 2'b00;
        push(4'b1111, 4'b0000, mk(8'h21, 3'b0), mk(8'h22, 3'b0), mk(8'h23, 3'b0), mk(8'h24, 3'b0));
        tick();
        idle();
        check("t3_ready_cnt4", 64'(ready), 64'd1);
        push(4'b0001, 4'b0000, mk(8'h25, 3'b0), '0, '0, '0);
        tick();
        idle();
        check("t3_ready_cnt5", 64'(ready), 64'd0);
        push(4'b1111, 4'b0000, mk(8'h71, 3'b0), mk(8'h72, 3'b0), mk(8'h73, 3'b0), mk(8'h74, 3'b0));
        repeat (5) tick();
        idle();
        check("t3_stall_ignored", 64'(ready), 64'd0);
        check("t3_hold_0a", 64'(inst0a), 64'(mk(8'h21, 3'b0)));
        check("t3_hold_ivalid", 64'(ivalid), 64'b0011);
        iq_ready = 2'b01;
        expect_tx(mk(8'h21, 3'b0), mk(8'h22, 3'b0), '0, '0, 4'b0011);
        tick();
        iq_ready = 2'b00;
        check("t3_ready_cnt3", 64'(ready), 64'd1);
        iq_ready = 2'b01;
        expect_tx(mk(8'h23, 3'b0), mk(8'h24, 3'b0), '0, '0, 4'b0011);
        expect_tx(mk(8'h25, 3'b0), '0, '0, '0, 4'b0001);
        tick();
        tick();
        iq_ready = 2'b00;
        check("t3_empty", 64'(ivalid), 64'd0);

        // Kill of a buffered entry: it drains as a bubble
        push(4'b0011, 4'b0000, mk(8'h31, 3'b010), mk(8'h32, 3'b001), '0, '0);
        tick();
        idle();
        kill = 3'b010;
        tick();
        kill = 3'b000;
        check("t4_killed_ivalid", 64'(ivalid), 64'b0010);
        check("t4_killed_0a", 64'(inst0a), 64'd0);
        iq_ready = 2'b01;
        expect_tx('0, mk(8'h32, 3'b001), '0, '0, 4'b0010);
        tick();
        iq_ready = 2'b00;
        check("t4_popped", 64'(ivalid), 64'd0);
`ifdef IQ_DISPATCH_STATS_EN
        check("stats_stall", 64'(stall_cnt), 64'd5);
        check("stats_kill", 64'(kill_cnt), 64'd1);
`endif

        // Kill in the enqueue cycle
        push(4'b0011, 4'b0000, mk(8'h41, 3'b001), mk(8'h42, 3'b000), '0, '0);
        kill = 3'b001;
        tick();
        idle();
        kill = 3'b000;
        iq_ready = 2'b01;
        expect_tx('0, mk(8'h42, 3'b0), '0, '0, 4'b0010);
        tick();
        iq_ready = 2'b00;

        // Kill while presented on lane 1
        push(4'b0011, 4'b0011, mk(8'h51, 3'b100), mk(8'h52, 3'b000), '0, '0);
        tick();
        idle();
        kill = 3'b100;
        iq_ready = 2'b10;
        expect_tx('0, '0, '0, mk(8'h52, 3'b0), 4'b1000);
        tick();
        kill = 3'b000;
        iq_ready = 2'b00;
        check("t4c_popped", 64'(ivalid), 64'd0);

        // Lane 1 pointer wrap
        for (int r = 0; r < 3; r++) begin
            logic [7:0] base;
            base = 8'h60 + 8'(4 * r);
            push(4'b1111, 4'b1111, mk(base + 8'd1, 3'b0), mk(base + 8'd2, 3'b0),
                 mk(base + 8'd3, 3'b0), mk(base + 8'd4, 3'b0));
            tick();
            idle();
            check("t5_ready", 64'(ready), 64'd1);
            iq_ready = 2'b10;
            expect_tx('0, '0, mk(base + 8'd1, 3'b0), mk(base + 8'd2, 3'b0), 4'b1100);
            expect_tx('0, '0, mk(base + 8'd3, 3'b0), mk(base + 8'd4, 3'b0), 4'b1100);
            tick();
            tick();
            iq_ready = 2'b00;
        end

        // Simultaneous push and pop holds lane 1 at two entries
        for (int i = 0; i < 8; i++) g[i] = mk(8'h90 + 8'(i), 3'b0);
        push(4'b0011, 4'b0011, g[0], g[1], '0, '0);
        tick();
        iq_ready = 2'b10;
        for (int i = 0; i < 3; i++) begin
            push(4'b0011, 4'b0011, g[2*i+2], g[2*i+3], '0, '0);
            expect_tx('0, '0, g[2*i], g[2*i+1], 4'b1100);
            tick();
            check("t5_steady_valid", 64'(ivalid[3:2]), 64'b11);
            check("t5_steady_ready", 64'(ready), 64'd1);
        end
        idle();
        expect_tx('0, '0, g[6], g[7], 4'b1100);
        tick();
        iq_ready = 2'b00;
        check("t5_drained", 64'(ivalid), 64'd0);

        // Reset mid-operation discards buffered uops
        push(4'b0001, 4'b0000, mk(8'hA1, 3'b0), '0, '0, '0);
        tick();
        idle();
        check("t6_buffered", 64'(ivalid), 64'b0001);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("t6_discard_ivalid", 64'(ivalid), 64'd0);
        check("t6_discard_0a", 64'(inst0a), 64'd0);
        check("t6_ready", 64'(ready), 64'd1);

        repeat (3) tick();
        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
